// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator sequencing controller.
//   - one-hot opcode constants as seen by the ALU
//   - controller state encoding (also exported on state_dbg)
//   - bit offsets of the fields inside the packed nr_coded word
package calc_pkg;

   localparam logic [3:0] OP_NONE = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_DIV  = 4'b1000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GET_A = 3'd1,
      S_GET_OP= 3'd2,
      S_GET_B = 3'd3,
      S_ISSUE = 3'd4,
      S_WAIT  = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   // nr_coded = {a, b, opcode}
   localparam int NR_A_LSB  = 8;
   localparam int NR_B_LSB  = 4;
   localparam int NR_OP_LSB = 0;

   function automatic logic is_onehot_op(input logic [3:0] v);
      return (v == OP_ADD) || (v == OP_SUB) || (v == OP_MUL) || (v == OP_DIV);
   endfunction

endpackage

// File: rtl/calc_lat_timer.sv
// calc_lat_timer: loadable up-counter with a terminal-count flag.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : force count to 0 (highest priority)
//   load_i    : load count with 1 (first cycle of an operation)
//   en_i      : increment count
//   tc_o      : count equals TC_VAL
module calc_lat_timer #(
   parameter int CNT_W  = 4,
   parameter int TC_VAL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] TC_W = CNT_W'(TC_VAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)       cnt_d = '0;
      else if (load_i) cnt_d = CNT_W'(1);
      else if (en_i)   cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_W);

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: key-sequencing controller for the 4-bit calculator ALU.
// Collects operand A, operator, operand B and equals from one-cycle key
// pulses, issues {a,b,opcode} to the ALU on nr_coded, waits ALU_LAT cycles,
// then captures result_in into result_out.
//   clk, rst                 : clock, synchronous active-high reset
//   digit_valid/digit        : digit key pulse and value
//   op_valid/op              : operator key pulse and one-hot opcode
//   eq_valid, clr_valid      : equals / clear key pulses
//   nr_coded                 : {a, b, opcode} to the ALU
//   result_in                : ALU result
//   result_out/result_valid  : captured result for the display
//   busy                     : operation in flight (ISSUE/WAIT)
//   err                      : sticky invalid-operator / divide-by-zero flag
//   state_dbg                : current state encoding
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int ALU_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic        eq_valid,
   input  logic        clr_valid,
   output logic [11:0] nr_coded,
   input  logic [3:0]  result_in,
   output logic [3:0]  result_out,
   output logic        result_valid,
   output logic        busy,
   output logic        err,
   output logic [2:0]  state_dbg
);

   state_e      state_q, state_d;
   logic [3:0]  a_q, a_d, b_q, b_d, op_q, op_d;
   logic [11:0] nr_q, nr_d;
   logic [3:0]  res_q, res_d;
   logic        rv_q, rv_d, err_q, err_d;
   logic        tmr_clr, tmr_load, tmr_en, tmr_tc;

   calc_lat_timer #(
      .CNT_W  (CNT_W),
      .TC_VAL (ALU_LAT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tmr_clr),
      .load_i (tmr_load),
      .en_i   (tmr_en),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      nr_d     = nr_q;
      res_d    = res_q;
      rv_d     = rv_q;
      err_d    = err_q;
      tmr_clr  = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;

      if (clr_valid) begin
         // Abandons any in-flight operation; operand fields of nr_coded are
         // left alone but the opcode drops so the ALU reports 0.
         state_d = S_IDLE;
         a_d     = '0;
         b_d     = '0;
         op_d    = OP_NONE;
         res_d   = '0;
         rv_d    = 1'b0;
         err_d   = 1'b0;
         nr_d[NR_OP_LSB +: 4] = OP_NONE;
         tmr_clr = 1'b1;
      end else begin
         // Strict priority eq > op > digit: the highest pulse present is the
         // only one considered, even where it has no effect in this state.
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (!eq_valid && !op_valid && digit_valid) begin
                  a_d     = digit;
                  rv_d    = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_GET_A;
               end
            end
            S_GET_A, S_GET_OP: begin
               if (eq_valid) begin
                  // ignored
               end else if (op_valid) begin
                  if (is_onehot_op(op)) begin
                     op_d    = op;
                     state_d = S_GET_OP;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (digit_valid) begin
                  if (state_q == S_GET_A) begin
                     a_d = digit;
                  end else begin
                     b_d     = digit;
                     state_d = S_GET_B;
                  end
               end
            end
            S_GET_B: begin
               if (eq_valid) begin
                  if (op_q == OP_DIV && b_q == 4'd0) begin
                     err_d   = 1'b1;
                     res_d   = '0;
                     rv_d    = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end else if (!op_valid && digit_valid) begin
                  b_d = digit;
               end
            end
            S_ISSUE: begin
               nr_d     = {a_q, b_q, op_q};
               tmr_load = 1'b1;
               state_d  = S_WAIT;
            end
            S_WAIT: begin
               if (tmr_tc) begin
                  res_d   = result_in;
                  rv_d    = 1'b1;
                  nr_d[NR_OP_LSB +: 4] = OP_NONE;
                  state_d = S_DONE;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_NONE;
         nr_q    <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         nr_q    <= nr_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign nr_coded     = nr_q;
   assign result_out   = res_q;
   assign result_valid = rv_q;
   assign err          = err_q;
   assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign state_dbg    = state_q;

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Sequencing controller for the 4-bit calculator ALU. It collects key events from the button decoder: first operand, operator, second operand, then equals. It drives the ALU's packed 12-bit operand/opcode word and waits a fixed latency. It then captures the ALU result for the display path and flags invalid operations. It sits between the button/debounce logic and the ALU, and the display mux reads its outputs.

Parameters:
ALU_LAT, 2, cycles from first cycle nr_coded carries a nonzero opcode to the cycle result_in is sampled; legal 1..15.
CNT_W, 4, width of latency counter; must hold ALU_LAT.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
digit_valid  in  1  one-cycle pulse: digit key pressed
digit  in  4  digit value 0..15, valid with digit_valid
op_valid  in  1  one-cycle pulse: operator key pressed
op  in  4  one-hot opcode: 0001 add, 0010 sub, 0100 mult, 1000 div
eq_valid  in  1  one-cycle pulse: equals key
clr_valid  in  1  one-cycle pulse: clear key
nr_coded  out  12  {a[11:8], b[7:4], opcode[3:0]} to ALU
result_in  in  4  ALU result
result_out  out  4  captured result for display
result_valid  out  1  high while result_out holds a fresh result
busy  out  1  high in ISSUE and WAIT
err  out  1  sticky error flag until next clear or new first digit
state_dbg  out  3  current state encoding, for LED debug

Behaviour:
- Reset (synchronous): state=IDLE, a=b=op_reg=0, nr_coded=0, result_out=0, result_valid=0, busy=0, err=0, counter=0.
- States: IDLE(0), GET_A(1), GET_OP(2), GET_B(3), ISSUE(4), WAIT(5), DONE(6).
- Priority of simultaneous pulses, every state: clr_valid > eq_valid > op_valid > digit_valid. Lower-priority pulses in the same cycle are dropped.
- clr_valid, any state, including ISSUE/WAIT: next state IDLE. a, b, op_reg, result_out, result_valid and err are cleared. counter is cleared. An in-flight operation is abandoned.
- IDLE/DONE + digit_valid: a<=digit, result_valid<=0, err<=0, next state GET_A.
- GET_A + digit_valid: a<=digit. Last digit wins (single 4-bit operand).
- GET_A + op_valid: if op is one-hot, op_reg<=op and next state GET_OP. Otherwise err<=1 and state is unchanged.
- GET_OP + op_valid: op_reg is replaced, with the same one-hot check. GET_OP + digit_valid: b<=digit, next state GET_B.
- GET_B + digit_valid: b<=digit (last wins). GET_B + op_valid: ignored.
- GET_B + eq_valid: if op_reg=1000 and b=0, err<=1, result_out<=0, result_valid<=1, next state DONE (no issue). Otherwise next state ISSUE.
- eq_valid in IDLE, GET_A or GET_OP: ignored.
- ISSUE, one cycle: nr_coded<={a,b,op_reg}, counter<=1, busy=1, next state WAIT.
- WAIT: nr_coded holds. Counter increments each cycle.
- WAIT, when counter==ALU_LAT: result_out<=result_in, result_valid<=1, nr_coded opcode field<=0000, next state DONE.
- Latency: eq_valid cycle T; nr_coded valid from T+2; result_out valid from T+2+ALU_LAT.
- Outside ISSUE/WAIT, nr_coded opcode field = 0000, so the ALU reports 0. The operand fields keep their last value.
- busy=1 only in ISSUE and WAIT. digit/op/eq pulses during busy are ignored.
- DONE: result_out and result_valid hold until clr_valid or a new digit. op_valid in DONE is ignored.
- Arithmetic is performed by the ALU only. The controller does no width extension. result_in is taken as 4-bit, with overflow truncation owned by the ALU.

Decomposition:
- Shared package calc_pkg holds:
  - opcode localparams OP_NONE=4'b0000, OP_ADD=4'b0001, OP_SUB=4'b0010, OP_MUL=4'b0100, OP_DIV=4'b1000;
  - state encodings S_IDLE..S_DONE;
  - the nr_coded field offsets.
- One sub-module: calc_lat_timer (loadable up-counter with terminal-count flag, parameter CNT_W). Everything else stays in one FSM module.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT -> all outputs 0, state_dbg=0 the cycle after rst is sampled.
- Add: digit 3, op 0001, digit 4, eq -> nr_coded=0x341 at T+2; with ALU_LAT=2, result_out=7, result_valid=1 at T+4; busy high for exactly 3 cycles.
- Divide by zero: digit 8, op 1000, digit 0, eq -> err=1, result_valid=1, result_out=0, nr_coded opcode never nonzero.
- Invalid/override: digit 5, op 0011 -> err=1, stays GET_A. Then op 0100 -> GET_OP. Then op 0010 -> op_reg=0010 (override). Then digit 2, eq -> nr_coded=0x522.
- Simultaneous/abort: clr_valid and eq_valid in the same cycle in GET_B -> IDLE, no issue. clr during WAIT -> IDLE next cycle, result_valid stays 0, late result_in ignored.
- Last-digit-wins and DONE restart: digits 1,9 then op 0001, digit 2, eq -> nr_coded=0x921. Then digit 6 in DONE -> result_valid=0, a=6, state GET_A.
